// File: rtl/tb_exit_periph.sv
// tb_exit_periph: memory-mapped bench peripheral on the core data OBI port.
//   Status register: writing PASS_MAGIC or FAIL_MAGIC pulses tests_passed_o or
//     tests_failed_o for one cycle.
//   Exit register:   each write latches exit_value_o and pulses exit_valid_o.
//   Stdout register: each write pushes a character into a small FIFO that the
//     bench drains with a valid/ready handshake.
//   Cycle register:  read-only free-running 32-bit cycle counter.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   req_i/we_i/be_i/addr_i/wdata_i       OBI request channel
//   gnt_o                                combinational grant
//   rvalid_o/rdata_o                     registered response, one cycle after grant
//   tests_passed_o/tests_failed_o        one-cycle result pulses
//   exit_valid_o/exit_value_o            exit pulse and held exit code
//   char_valid_o/char_o/char_ready_i     stdout FIFO head and pop handshake
module tb_exit_periph #(
  parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004,
  parameter logic [31:0] STDOUT_ADDR = 32'h1000_0000,
  parameter logic [31:0] CYCLE_ADDR  = 32'h1500_1000,
  parameter logic [31:0] PASS_MAGIC  = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC  = 32'd1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i
);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = PW - 1;

  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          passed_q, passed_d;
  logic          failed_q, failed_d;
  logic          exit_vld_q, exit_vld_d;
  logic [31:0]   exit_val_q, exit_val_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic hit_status, hit_exit, hit_stdout, hit_cycle;
  logic full, empty, stdout_wr, gnt, wr_full, push, pop;

  assign hit_status = addr_i[31:2] == STATUS_ADDR[31:2];
  assign hit_exit   = addr_i[31:2] == EXIT_ADDR[31:2];
  assign hit_stdout = addr_i[31:2] == STDOUT_ADDR[31:2];
  assign hit_cycle  = addr_i[31:2] == CYCLE_ADDR[31:2];

  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Full is taken from registered pointers, so a pop this cycle cannot
  // unblock a stdout write until the following cycle.
  assign stdout_wr = req_i && we_i && hit_stdout;
  assign gnt       = req_i && !rst_i && !(stdout_wr && full);
  assign wr_full   = gnt && we_i && (be_i == 4'hF);
  assign push      = gnt && stdout_wr;
  assign pop       = !empty && char_ready_i;

  always_comb begin
    rvalid_d   = gnt;
    rdata_d    = (gnt && !we_i && hit_cycle) ? cnt_q : 32'd0;
    passed_d   = wr_full && hit_status && (wdata_i == PASS_MAGIC);
    failed_d   = wr_full && hit_status && (wdata_i == FAIL_MAGIC);
    exit_vld_d = wr_full && hit_exit;
    exit_val_d = exit_vld_d ? wdata_i : exit_val_q;
    cnt_d      = cnt_q + 32'd1;
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    mem_d      = mem_q;
    if (push) mem_d[wptr_q[AW-1:0]] = wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      passed_q   <= 1'b0;
      failed_q   <= 1'b0;
      exit_vld_q <= 1'b0;
      exit_val_q <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      passed_q   <= passed_d;
      failed_q   <= failed_d;
      exit_vld_q <= exit_vld_d;
      exit_val_q <= exit_val_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) mem_q <= mem_d;

  assign gnt_o          = gnt;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_vld_q;
  assign exit_value_o   = exit_val_q;
  assign char_valid_o   = !empty;
  assign char_o         = empty ? 8'd0 : mem_q[rptr_q[AW-1:0]];
endmodule

// File: doc/tb_exit_periph.md
Name: tb_exit_periph

Overview:
Memory-mapped testbench peripheral on the core's data OBI port. It produces the test-result and exit signals that the top-level bench watches: tests_passed_o, tests_failed_o, exit_valid_o and exit_value_o. It also buffers stdout characters for the bench and provides a readable cycle counter. It responds to core-initiated transactions and sits inside the tb wrapper, next to the RAM.

Parameters:
STATUS_ADDR, 32'h2000_0000, word address of the test-status register
EXIT_ADDR, 32'h2000_0004, word address of the exit-code register
STDOUT_ADDR, 32'h1000_0000, word address of the stdout character register
CYCLE_ADDR, 32'h1500_1000, word address of the read-only cycle counter
PASS_MAGIC, 32'd123456789, status write value that signals pass
FAIL_MAGIC, 32'd1, status write value that signals fail
FIFO_DEPTH, 4, number of stdout FIFO entries (power of 2, at least 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  1  OBI request
we_i  in  1  write enable (1 = write)
be_i  in  4  byte enables
addr_i  in  32  byte address; only matched on addr_i[31:2]
wdata_i  in  32  write data
gnt_o  out  1  OBI grant (combinational)
rvalid_o  out  1  response valid
rdata_o  out  32  response read data
tests_passed_o  out  1  one-cycle pulse
tests_failed_o  out  1  one-cycle pulse
exit_valid_o  out  1  one-cycle pulse
exit_value_o  out  32  last exit code written
char_valid_o  out  1  stdout FIFO not empty
char_o  out  8  stdout FIFO head character
char_ready_i  in  1  bench pops the head character when high together with char_valid_o

Behaviour:
- Reset (synchronous, active-high): all outputs go to 0, the FIFO empties and the cycle counter clears. Reset dominates every other event in the same cycle. Any transaction in flight is dropped; no rvalid_o is issued for it.
- Decode: a transaction "hits X" when addr_i[31:2] == X[31:2]. Unmatched addresses are granted, writes to them are ignored, and reads return 0.
- Grant: gnt_o = req_i && !(stdout_write && fifo_full). stdout_write means req_i && we_i && the transaction hits STDOUT_ADDR. Requests are never granted while rst_i is high.
- Response: every granted transaction gives rvalid_o = 1 in the next cycle only. Outstanding transactions are limited to 1 by construction, so back-to-back grants give back-to-back rvalid_o.
- rdata_o:
  - Registered with rvalid_o.
  - Read of CYCLE_ADDR returns the counter value in the grant cycle.
  - All other reads return 0.
  - On writes rdata_o is 0.
- Status register (granted write, be_i == 4'hF):
  - wdata == PASS_MAGIC: tests_passed_o = 1 in the next cycle for one cycle.
  - wdata == FAIL_MAGIC: tests_failed_o pulses the same way.
  - Any other value is ignored.
  - Partial byte enables are ignored.
- Exit register (granted write, be_i == 4'hF): exit_value_o <= wdata and exit_valid_o pulses in the next cycle. exit_value_o holds until the next exit write or reset. Partial writes are ignored.
- Stdout:
  - A granted write pushes wdata_i[7:0], regardless of be_i.
  - The FIFO uses a circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; pointers wrap naturally.
  - Full is when the pointers differ only in the MSB; empty is when the pointers are equal.
  - char_valid_o = !empty; char_o = the head entry (combinational from storage).
  - Pop happens on char_valid_o && char_ready_i.
  - Push and pop in the same cycle: both happen. When full, the push is not granted, so a pop that cycle does not enable a same-cycle grant. The grant occurs next cycle.
- Cycle counter: 32-bit, increments by 1 every cycle after reset and wraps from 32'hFFFF_FFFF to 0. Writes to CYCLE_ADDR are ignored.
- Pulse outputs are never asserted together by a single transaction. Pulses from consecutive transactions appear in consecutive cycles.

Test Plan:
- Reset: after reset, write 32'd123456789 to 0x2000_0000 with be=F -> gnt_o same cycle; next cycle rvalid_o=1 and tests_passed_o=1 for exactly one cycle; tests_failed_o stays 0.
- Status values: write 32'd1 to 0x2000_0000 -> tests_failed_o pulses once. Write 32'd5 -> no pulse. Write 32'd1 with be=4'h1 -> no pulse, rvalid_o still 1.
- Exit register: write 32'd0 then 32'd7 to 0x2000_0004 in consecutive cycles -> exit_valid_o high for 2 cycles; exit_value_o = 0, then 7, then holds 7.
- Stdout backpressure: char_ready_i=0; write 'A','B','C','D','E' to 0x1000_0000 -> first 4 granted, fifth gnt_o=0. Raise char_ready_i -> chars pop in order A,B,C,D, the fifth is granted one cycle after the first pop, and E follows D.
- Cycle counter: read 0x1500_1000 at grant cycle N after reset -> rdata_o = N with rvalid_o at N+1. Read 0x3000_0000 -> rdata_o = 0.
- Reset mid-operation: assert rst_i in the cycle after a granted exit write, with 2 chars queued -> rvalid_o=0, exit_value_o=0, char_valid_o=0 and the counter reads 0 after release.
